// File: rtl/dram_burst_reader.sv
// dram_burst_reader
//   AXI4 read master that turns one DRAM read command (start address and
//   beat count) into one or two INCR bursts. A command is split when it would
//   cross a 4 KB page. Returned R beats are forwarded one cycle after each
//   R handshake. Protocol and response problems are recorded in a sticky
//   error register.
//
// Ports
//   clk_pixel, dram_reader_reset_n         clock, async active-low reset
//   dram_read_addr/len/en                  command in (len = beats - 1)
//   dram_read_busy                         command in progress
//   dram_read_data/_valid                  forwarded R beats
//   dram_read_error/_clear                 sticky flags {drop, rlast, rresp}
//   m_axi_ar*                              AXI read address channel
//   m_axi_r*                               AXI read data channel
module dram_burst_reader #(
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 128
) (
    input  logic                       clk_pixel,
    input  logic                       dram_reader_reset_n,
    input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
    input  logic [7:0]                 dram_read_len,
    input  logic                       dram_read_en,
    output logic                       dram_read_busy,
    output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    output logic                       dram_read_data_valid,
    output logic [2:0]                 dram_read_error,
    input  logic                       dram_read_error_clear,
    output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    localparam int BPB        = DRAM_DATA_WIDTH / 8;
    localparam int LSB        = $clog2(BPB);
    localparam int PAGE_BEATS = 4096 / BPB;
    localparam logic [DRAM_ADDR_WIDTH-1:0] ALIGN_MASK = ~DRAM_ADDR_WIDTH'(BPB - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    // Beats that fit before the next 4 KB page boundary, capped at what is left.
    function automatic logic [8:0] calc_burst(input logic [11-LSB:0] beat_off,
                                              input logic [8:0]      rem);
        logic [12:0] room;
        room = 13'(PAGE_BEATS) - 13'(beat_off);
        if ({4'd0, rem} < room)
            return rem;
        else
            return room[8:0];
    endfunction

    state_t                       state_reg, state_next;
    logic [DRAM_ADDR_WIDTH-1:0]   cur_addr_reg, cur_addr_next;
    logic [8:0]                   remaining_reg, remaining_next;
    logic [8:0]                   burst_reg, burst_next;
    logic [8:0]                   beat_cnt_reg, beat_cnt_next;
    logic                         arvalid_reg, arvalid_next;
    logic [DRAM_ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
    logic [7:0]                   arlen_reg, arlen_next;
    logic [DRAM_DATA_WIDTH-1:0]   data_reg, data_next;
    logic                         data_valid_reg, data_valid_next;
    logic [2:0]                   error_reg, error_next;
    logic                         busy_reg, busy_next;

    logic [DRAM_ADDR_WIDTH-1:0]   aligned_addr;
    logic [8:0]                   load_rem;
    logic [8:0]                   new_burst;
    logic [8:0]                   beat_num;
    logic [2:0]                   err_set;

    always_ff @(posedge clk_pixel or negedge dram_reader_reset_n) begin
        if (!dram_reader_reset_n) begin
            state_reg      <= IDLE;
            cur_addr_reg   <= '0;
            remaining_reg  <= '0;
            burst_reg      <= '0;
            beat_cnt_reg   <= '0;
            arvalid_reg    <= 1'b0;
            araddr_reg     <= '0;
            arlen_reg      <= '0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            error_reg      <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cur_addr_reg   <= cur_addr_next;
            remaining_reg  <= remaining_next;
            burst_reg      <= burst_next;
            beat_cnt_reg   <= beat_cnt_next;
            arvalid_reg    <= arvalid_next;
            araddr_reg     <= araddr_next;
            arlen_reg      <= arlen_next;
            data_reg       <= data_next;
            data_valid_reg <= data_valid_next;
            error_reg      <= error_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cur_addr_next   = cur_addr_reg;
        remaining_next  = remaining_reg;
        burst_next      = burst_reg;
        beat_cnt_next   = beat_cnt_reg;
        arvalid_next    = arvalid_reg;
        araddr_next     = araddr_reg;
        arlen_next      = arlen_reg;
        data_next       = data_reg;
        data_valid_next = 1'b0;
        err_set         = 3'b000;
        aligned_addr    = dram_read_addr & ALIGN_MASK;
        load_rem        = {1'b0, dram_read_len} + 9'd1;
        new_burst       = '0;
        beat_num        = beat_cnt_reg + 9'd1;

        unique case (state_reg)
            IDLE: begin
                // The AR registers are loaded here so arvalid rises the cycle
                // after the command strobe.
                if (dram_read_en) begin
                    new_burst      = calc_burst(aligned_addr[11:LSB], load_rem);
                    cur_addr_next  = aligned_addr;
                    remaining_next = load_rem;
                    burst_next     = new_burst;
                    arvalid_next   = 1'b1;
                    araddr_next    = aligned_addr;
                    arlen_next     = 8'(new_burst - 9'd1);
                    state_next     = ADDR;
                end
            end
            ADDR: begin
                if (m_axi_arready) begin
                    arvalid_next   = 1'b0;
                    beat_cnt_next  = '0;
                    cur_addr_next  = cur_addr_reg + (DRAM_ADDR_WIDTH'(burst_reg) << LSB);
                    remaining_next = remaining_reg - burst_reg;
                    state_next     = DATA;
                end
            end
            DATA: begin
                if (m_axi_rvalid) begin
                    data_next       = m_axi_rdata;
                    data_valid_next = 1'b1;
                    beat_cnt_next   = beat_num;
                    if (m_axi_rresp != 2'b00)
                        err_set[0] = 1'b1;
                    if (m_axi_rlast) begin
                        // An early rlast ends the burst; the short fall is not re-fetched.
                        if (beat_num != burst_reg)
                            err_set[1] = 1'b1;
                        if (remaining_reg != 9'd0) begin
                            new_burst    = calc_burst(cur_addr_reg[11:LSB], remaining_reg);
                            burst_next   = new_burst;
                            arvalid_next = 1'b1;
                            araddr_next  = cur_addr_reg;
                            arlen_next   = 8'(new_burst - 9'd1);
                            state_next   = ADDR;
                        end else begin
                            state_next   = IDLE;
                        end
                    end else if (beat_num == burst_reg) begin
                        // Missing rlast: keep forwarding until it shows up.
                        err_set[1] = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (dram_read_en && (state_reg != IDLE))
            err_set[2] = 1'b1;

        // A new error in the same cycle as a clear survives the clear.
        error_next = (dram_read_error_clear ? 3'b000 : error_reg) | err_set;
        busy_next  = (state_next != IDLE);
    end

    assign dram_read_busy       = busy_reg;
    assign dram_read_data       = data_reg;
    assign dram_read_data_valid = data_valid_reg;
    assign dram_read_error      = error_reg;
    assign m_axi_araddr         = araddr_reg;
    assign m_axi_arlen          = arlen_reg;
    assign m_axi_arsize         = 3'(LSB);
    assign m_axi_arburst        = 2'b01;
    assign m_axi_arvalid        = arvalid_reg;
    assign m_axi_rready         = (state_reg == DATA);

endmodule

// File: tb/tb_dram_burst_reader.sv
`timescale 1ns/1ps
module tb_dram_burst_reader;

    localparam int AW = 39;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] dram_read_addr;
    logic [7:0]    dram_read_len;
    logic          dram_read_en;
    logic          dram_read_busy;
    logic [DW-1:0] dram_read_data;
    logic          dram_read_data_valid;
    logic [2:0]    dram_read_error;
    logic          dram_read_error_clear;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;

    always #5 clk = ~clk;

    dram_burst_reader #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) dut (
        .clk_pixel            (clk),
        .dram_reader_reset_n  (rst_n),
        .dram_read_addr       (dram_read_addr),
        .dram_read_len        (dram_read_len),
        .dram_read_en         (dram_read_en),
        .dram_read_busy       (dram_read_busy),
        .dram_read_data       (dram_read_data),
        .dram_read_data_valid (dram_read_data_valid),
        .dram_read_error      (dram_read_error),
        .dram_read_error_clear(dram_read_error_clear),
        .m_axi_araddr         (m_axi_araddr),
        .m_axi_arlen          (m_axi_arlen),
        .m_axi_arsize         (m_axi_arsize),
        .m_axi_arburst        (m_axi_arburst),
        .m_axi_arvalid        (m_axi_arvalid),
        .m_axi_arready        (m_axi_arready),
        .m_axi_rdata          (m_axi_rdata),
        .m_axi_rresp          (m_axi_rresp),
        .m_axi_rlast          (m_axi_rlast),
        .m_axi_rvalid         (m_axi_rvalid),
        .m_axi_rready         (m_axi_rready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Every forwarded beat must match the oldest driven beat and arrive one
    // cycle after it was offered on the R channel.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (dram_read_data_valid) begin
            if (sb.size() == 0) begin
                check_val("unexpected_beat", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("beat_data", dram_read_data, e.data);
                check_val("beat_latency", cyc, e.cyc + 1);
                $display("beat data=0x%0h cycle=%0d", dram_read_data, cyc);
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input logic [7:0] l);
        @(negedge clk);
        check_val("busy_before_cmd", dram_read_busy, 0);
        dram_read_addr = a;
        dram_read_len  = l;
        dram_read_en   = 1'b1;
        $display("cmd addr=0x%0h len=%0d", a, l);
        @(negedge clk);
        dram_read_en = 1'b0;
        check_val("busy_after_cmd", dram_read_busy, 1);
    endtask

    task automatic wait_ar(input int hold, output logic [AW-1:0] a, output logic [7:0] l,
                           output int waited);
        waited = 0;
        a = '0;
        l = '0;
        while (!m_axi_arvalid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!m_axi_arvalid) begin
            check_val("ar_timeout", 0, 1);
            return;
        end
        a = m_axi_araddr;
        l = m_axi_arlen;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("ar_hold_valid", m_axi_arvalid, 1);
            check_val("ar_hold_addr", m_axi_araddr, a);
            check_val("ar_hold_len", m_axi_arlen, l);
        end
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        check_val("ar_low_after_hs", m_axi_arvalid, 0);
        $display("ar addr=0x%0h len=%0d waited=%0d", a, l, waited);
    endtask

    task automatic send_beats(input int n, input int slverr_idx, input int last_idx);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            check_val("rready_in_data", m_axi_rready, 1);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
            m_axi_rresp  = (i == slverr_idx) ? 2'b10 : 2'b00;
            m_axi_rlast  = (i == last_idx);
            e.data = m_axi_rdata;
            e.cyc  = cyc;
            sb.push_back(e);
            @(negedge clk);
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
    endtask

    task automatic pulse_clear();
        dram_read_error_clear = 1'b1;
        @(negedge clk);
        dram_read_error_clear = 1'b0;
        @(negedge clk);
        check_val("error_cleared", dram_read_error, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [7:0]    l;
        int            w;
        int            seen;

        rst_n = 1'b0;
        dram_read_addr = '0;
        dram_read_len = '0;
        dram_read_en = 1'b0;
        dram_read_error_clear = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rdata = '0;
        m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0;

        #12;
        check_val("rst_busy", dram_read_busy, 0);
        check_val("rst_arvalid", m_axi_arvalid, 0);
        check_val("rst_rready", m_axi_rready, 0);
        check_val("rst_data_valid", dram_read_data_valid, 0);
        check_val("rst_data", dram_read_data, 0);
        check_val("rst_araddr", m_axi_araddr, 0);
        check_val("rst_arlen", m_axi_arlen, 0);
        check_val("rst_error", dram_read_error, 0);
        check_val("arsize", m_axi_arsize, 3'd4);
        check_val("arburst", m_axi_arburst, 2'b01);
        @(negedge clk);
        rst_n = 1'b1;

        // single burst
        send_cmd(39'h0_1000_0000, 8'd7);
        wait_ar(0, a, l, w);
        check_val("t1_araddr", a, 39'h0_1000_0000);
        check_val("t1_arlen", l, 7);
        check_val("t1_ar_rise", w, 0);
        send_beats(8, -1, 7);
        check_val("t1_busy_fall", dram_read_busy, 0);
        check_val("t1_rready_fall", m_axi_rready, 0);
        check_val("t1_error", dram_read_error, 0);

        // 4 KB split
        send_cmd(39'h0FF0, 8'd3);
        wait_ar(0, a, l, w);
        check_val("t2_ar1_addr", a, 39'h0FF0);
        check_val("t2_ar1_len", l, 0);
        send_beats(1, -1, 0);
        check_val("t2_ar2_rise", m_axi_arvalid, 1);
        check_val("t2_busy_mid", dram_read_busy, 1);
        wait_ar(0, a, l, w);
        check_val("t2_ar2_addr", a, 39'h1000);
        check_val("t2_ar2_len", l, 2);
        send_beats(3, -1, 2);
        check_val("t2_busy_fall", dram_read_busy, 0);

        // AR backpressure and alignment
        send_cmd(39'h1007, 8'd0);
        wait_ar(5, a, l, w);
        check_val("t3_araddr", a, 39'h1000);
        check_val("t3_arlen", l, 0);
        send_beats(1, -1, 0);
        check_val("t3_busy_fall", dram_read_busy, 0);
        check_val("t3_error", dram_read_error, 0);

        // SLVERR on beat 2 of 4
        send_cmd(39'h2000, 8'd3);
        wait_ar(0, a, l, w);
        send_beats(4, 1, 3);
        check_val("t4_error", dram_read_error, 3'b001);
        check_val("t4_busy_fall", dram_read_busy, 0);
        pulse_clear();

        // early rlast on beat 3 of 4
        send_cmd(39'h2040, 8'd3);
        wait_ar(0, a, l, w);
        check_val("t5_arlen", l, 3);
        send_beats(3, -1, 2);
        check_val("t5_busy_fall", dram_read_busy, 0);
        check_val("t5_rready_fall", m_axi_rready, 0);
        check_val("t5_error", dram_read_error, 3'b010);
        @(negedge clk);
        check_val("t5_no_refetch", m_axi_arvalid, 0);
        pulse_clear();

        // dropped command, with a clear in the same cycle
        send_cmd(39'h3000, 8'd1);
        wait_ar(0, a, l, w);
        dram_read_addr = 39'h5000;
        dram_read_len = 8'd9;
        dram_read_en = 1'b1;
        dram_read_error_clear = 1'b1;
        @(negedge clk);
        dram_read_en = 1'b0;
        dram_read_error_clear = 1'b0;
        check_val("t6_drop_err", dram_read_error, 3'b100);
        send_beats(2, -1, 1);
        check_val("t6_busy_fall", dram_read_busy, 0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_axi_arvalid) seen++;
        end
        check_val("t6_no_extra_ar", seen, 0);

        // reset in the middle of an 8-beat burst
        send_cmd(39'h4000, 8'd7);
        wait_ar(0, a, l, w);
        send_beats(2, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t7_busy", dram_read_busy, 0);
        check_val("t7_arvalid", m_axi_arvalid, 0);
        check_val("t7_rready", m_axi_rready, 0);
        check_val("t7_data_valid", dram_read_data_valid, 0);
        check_val("t7_data", dram_read_data, 0);
        check_val("t7_araddr", m_axi_araddr, 0);
        check_val("t7_arlen", m_axi_arlen, 0);
        check_val("t7_error", dram_read_error, 0);
        check_val("t7_sb_empty", sb.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_val("t7_stray_rready", m_axi_rready, 0);
            m_axi_rvalid = 1'b1;
            m_axi_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            m_axi_rlast = (i == 1);
            @(negedge clk);
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        @(negedge clk);
        check_val("t7_idle_busy", dram_read_busy, 0);
        send_cmd(39'h5000, 8'd1);
        wait_ar(0, a, l, w);
        check_val("t7_new_araddr", a, 39'h5000);
        check_val("t7_new_arlen", l, 1);
        send_beats(2, -1, 1);
        check_val("t7_new_busy", dram_read_busy, 0);
        check_val("t7_new_error", dram_read_error, 0);

        repeat (3) @(negedge clk);
        check_val("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_burst_reader.md
# dram_burst_reader

Single-clock AXI4 read master that sits directly downstream of the image sender's DRAM read request port (`dram_read_addr` / `dram_read_len` / `dram_read_en`) and feeds the returned beats back to it (`dram_read_data` / `dram_read_data_valid`, `dram_read_busy`). The block converts one read command into one or two AXI INCR bursts, splitting at 4 KB boundaries. It forwards R-channel data with one cycle of latency and reports protocol and response errors in a sticky status register.

## Interface
- `DRAM_ADDR_WIDTH`, default 39: byte address width for both the command port and `m_axi_araddr`.
- `DRAM_DATA_WIDTH`, default 128: data width in bits. Bytes per beat is `BPB = DRAM_DATA_WIDTH/8`.
- `clk_pixel`, in, 1: the only clock.
- `dram_reader_reset_n`, in, 1: reset, **asynchronous and active-low**.
- `dram_read_addr`, in, DRAM_ADDR_WIDTH: start byte address. The low `$clog2(BPB)` bits are forced to 0.
- `dram_read_len`, in, 8: beat count minus 1, so a command covers 1–256 beats.
- `dram_read_en`, in, 1: one-cycle command strobe.
- `dram_read_busy`, out, 1: high while a command is in progress.
- `dram_read_data`, out, DRAM_DATA_WIDTH: registered R beat.
- `dram_read_data_valid`, out, 1: qualifies `dram_read_data` for one cycle per beat.
- `dram_read_error`, out, 3: sticky error flags.
  - [0]: `rresp` ≠ OKAY.
  - [1]: `rlast` mismatch.
  - [2]: command dropped.
- `dram_read_error_clear`, in, 1: synchronous clear of `dram_read_error`.
- `m_axi_araddr`, out, DRAM_ADDR_WIDTH.
- `m_axi_arlen`, out, 8.
- `m_axi_arsize`, out, 3: constant `$clog2(BPB)`.
- `m_axi_arburst`, out, 2: constant 2'b01 (INCR).
- `m_axi_arvalid`, in `m_axi_arready`: AR handshake (out, in).
- `m_axi_rdata`, in, DRAM_DATA_WIDTH.
- `m_axi_rresp`, in, 2.
- `m_axi_rlast`, in, 1.
- `m_axi_rvalid`, in, 1.
- `m_axi_rready`, out, 1.

## Operation
- State machine: IDLE → ADDR → DATA → (ADDR | IDLE).
- **IDLE**
  - `dram_read_en` = 1 latches `cur_addr` (aligned address) and `remaining = dram_read_len + 1` (9 bits). Next state is ADDR.
- **ADDR**
  - `burst = min(remaining, 4096/BPB − cur_addr[11:$clog2(BPB)])`.
  - Drive `m_axi_arvalid` = 1, `m_axi_araddr = cur_addr`, `m_axi_arlen = burst − 1`.
  - All AR signals are registered and held stable until `arready`.
  - On handshake: `beat_cnt` = 0, `cur_addr += burst*BPB`, `remaining -= burst`. Next state is DATA.
- **DATA**
  - `m_axi_rready` = 1. Each `rvalid` is one beat: capture `rdata`, pulse `dram_read_data_valid`, increment `beat_cnt`.
  - `rresp` ≠ 0 on any beat sets error[0]. The beat is still forwarded.
  - `rlast` on a beat other than the `burst`-th sets error[1]. The burst ends at that `rlast` and the missing beats are not re-fetched.
  - The `burst`-th beat without `rlast` sets error[1]. Later beats are forwarded until `rlast`.
  - On the beat with `rlast`: go to ADDR if `remaining` > 0, otherwise go to IDLE.
- The consumer guarantees FIFO space before issuing a command. This block applies no R backpressure.
- `dram_read_en` outside IDLE: the command is ignored and error[2] is set.
- Error flags are sticky. `dram_read_error_clear` zeroes them; if clear and a new error occur in the same cycle, the set wins.

## Timing
- Reset (async assert, sync release) returns all outputs and state to these values:
  - State = IDLE.
  - `arvalid` = 0, `rready` = 0, `busy` = 0, `data_valid` = 0.
  - `dram_read_data` = 0, `araddr` = 0, `arlen` = 0, `dram_read_error` = 0.
- `dram_read_busy` = (state ≠ IDLE), registered. It rises the cycle after the accepted `dram_read_en` and falls the cycle after the final `rlast` beat.
- `m_axi_arvalid` rises the cycle after `dram_read_en`. It is never deasserted before `arready`.
- The second AR of a split rises the cycle after the first burst's `rlast` beat.
- Data latency: `dram_read_data_valid` is high exactly one cycle after each R handshake, with no bubbles added.
- `m_axi_rready` is high only in DATA and is deasserted the cycle after `rlast`.
- Reset mid-burst drops everything immediately. Outstanding R beats arriving after reset release while in IDLE are ignored (`rready` = 0).

## Test plan
- **Single burst:** en, addr 0x0_1000_0000, len 7 → one AR with `araddr` = 0x10000000 and `arlen` = 7; 8 valid beats, each 1 cycle after its `rvalid`. Busy is high 1 cycle after en and low 1 cycle after `rlast`. Error = 0.
- **4 KB split:** addr 0x0FF0, len 3 → AR#1 with `araddr` 0x0FF0, `arlen` 0; then AR#2 with `araddr` 0x1000, `arlen` 2. Total of 4 beats output.
- **AR backpressure and alignment:** `arready` low for 5 cycles, addr 0x1007 → `arvalid` and `araddr` = 0x1000 held stable all 5 cycles; the handshake occurs on cycle 6.
- **Errors:**
  - SLVERR on beat 2 of 4 → error = 3'b001 and all 4 beats are forwarded.
  - `rlast` on beat 3 of 4 → error[1] is set and the block returns to IDLE.
  - Clear → error = 0.
- **Dropped command:** en pulsed while busy → no extra AR is issued and error[2] = 1.
- **Reset mid-burst:** reset_n low during beat 3 of 8 → outputs return to their reset values asynchronously; a following command proceeds normally.
